// File: rtl/fir_cfg_ctrl_if.sv
// AXI4-Lite configuration bus between the host and fir_cfg_ctrl (no response codes).
interface fir_cfg_ctrl_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic              wvalid;
   logic              wready;
   logic [DATA_W-1:0] wdata;
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;

   modport master (
      output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
      input  awready, wready, arready, rvalid, rdata
   );
   modport slave (
      input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
      output awready, wready, arready, rvalid, rdata
   );
endinterface

// File: rtl/fir_cfg_ctrl.sv
// FIR configuration front-end: ap_ctrl/data_length registers, AXI-Lite slave,
// and arbitration of the single tap-coefficient RAM port between host and datapath.
module fir_cfg_ctrl #(
   parameter int unsigned pADDR_WIDTH = 12,
   parameter int unsigned pDATA_WIDTH = 32,
   parameter int unsigned Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   fir_cfg_ctrl_if.slave          axil,
   output logic [3:0]             tap_WE,
   output logic                   tap_EN,
   output logic [pDATA_WIDTH-1:0] tap_Di,
   output logic [pADDR_WIDTH-1:0] tap_A,
   input  logic [pDATA_WIDTH-1:0] tap_Do,
   input  logic                   core_tap_en,
   input  logic [pADDR_WIDTH-1:0] core_tap_A,
   output logic [pDATA_WIDTH-1:0] core_tap_Do,
   output logic                   ap_start_o,
   output logic [pDATA_WIDTH-1:0] data_length,
   input  logic                   core_done
);
   localparam int unsigned TAP_BYTES = 4 * Tape_Num;
   localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(32'h00);
   localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
   localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32'h20);
   localparam logic [pADDR_WIDTH-1:0] TAP_END   = pADDR_WIDTH'(32'h20 + TAP_BYTES);

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

   r_state_t               r_state;
   logic [pADDR_WIDTH-1:0] wr_addr;
   logic [pDATA_WIDTH-1:0] wr_data;
   logic [pADDR_WIDTH-1:0] rd_addr;
   logic                   rd_busy;
   logic                   ap_start;
   logic                   ap_done;
   logic                   ap_idle;

   logic                   wr_fire;
   logic                   host_tap_wr;
   logic                   host_tap_rd;
   logic                   rd_stall;
   logic [pDATA_WIDTH-1:0] rd_value;

   function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
      return (a >= TAP_BASE) && (a < TAP_END) && (a[1:0] == 2'b00);
   endfunction

   assign wr_fire     = axil.awvalid && axil.wvalid && !axil.awready;
   assign host_tap_wr = axil.awready && is_tap(wr_addr);
   assign host_tap_rd = (r_state == R_ADDR) && is_tap(rd_addr);
   // host write wins the RAM port; the read retries its address phase next cycle
   assign rd_stall    = ap_idle && host_tap_wr && host_tap_rd;
   assign ap_start_o  = ap_start;
   assign core_tap_Do = tap_Do;

   always_comb begin
      rd_value = '0;
      if (rd_addr == ADDR_CTRL) begin
         rd_value = pDATA_WIDTH'({ap_idle, ap_done, ap_start});
      end else if (rd_addr == ADDR_LEN) begin
         rd_value = data_length;
      end else if (is_tap(rd_addr)) begin
         rd_value = rd_busy ? '1 : tap_Do;
      end
   end

   // tap port: datapath owns it while running, host otherwise
   always_comb begin
      tap_EN = 1'b0;
      tap_WE = 4'h0;
      tap_A  = '0;
      tap_Di = '0;
      if (!ap_idle) begin
         tap_EN = core_tap_en;
         tap_A  = core_tap_A;
      end else if (host_tap_wr) begin
         tap_EN = 1'b1;
         tap_WE = 4'hF;
         tap_A  = wr_addr - TAP_BASE;
         tap_Di = wr_data;
      end else if (host_tap_rd) begin
         tap_EN = 1'b1;
         tap_A  = rd_addr - TAP_BASE;
      end
   end

   always_ff @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         axil.awready <= 1'b0;
         axil.wready  <= 1'b0;
         axil.arready <= 1'b0;
         axil.rvalid  <= 1'b0;
         axil.rdata   <= '0;
         r_state      <= R_IDLE;
         wr_addr      <= '0;
         wr_data      <= '0;
         rd_addr      <= '0;
         rd_busy      <= 1'b0;
         ap_start     <= 1'b0;
         ap_done      <= 1'b0;
         ap_idle      <= 1'b1;
         data_length  <= '0;
      end else begin
         axil.awready <= wr_fire;
         axil.wready  <= wr_fire;
         if (wr_fire) begin
            wr_addr <= axil.awaddr;
            wr_data <= axil.wdata;
         end

         ap_start <= 1'b0;
         if (ap_start) begin
            ap_idle <= 1'b0;
            ap_done <= 1'b0;
         end
         if (axil.awready && ap_idle) begin
            if (wr_addr == ADDR_CTRL && wr_data[0]) begin
               ap_start <= 1'b1;
            end
            if (wr_addr == ADDR_LEN) begin
               data_length <= wr_data;
            end
         end
         if (core_done && !ap_idle) begin
            ap_done <= 1'b1;
            ap_idle <= 1'b1;
         end

         case (r_state)
            R_IDLE: begin
               if (axil.arvalid) begin
                  r_state      <= R_ADDR;
                  axil.arready <= 1'b1;
                  rd_addr      <= axil.araddr;
               end
            end
            R_ADDR: begin
               axil.arready <= 1'b0;
               if (!rd_stall) begin
                  r_state <= R_DATA;
                  rd_busy <= !ap_idle;
               end
            end
            R_DATA: begin
               if (!axil.rvalid) begin
                  axil.rvalid <= 1'b1;
                  axil.rdata  <= rd_value;
               end else if (axil.rready) begin
                  axil.rvalid <= 1'b0;
                  r_state     <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Self-checking bench for fir_cfg_ctrl: directed sequence plus randomized host traffic,
// compared against a register/tap-array model of the host-visible behaviour.
module tb_fir_cfg_ctrl;
   localparam int TAPS = 11;

   logic        axis_clk = 1'b0;
   logic        axis_rst_n;
   logic [3:0]  tap_WE;
   logic        tap_EN;
   logic [31:0] tap_Di;
   logic [11:0] tap_A;
   logic [31:0] tap_Do;
   logic        core_tap_en;
   logic [11:0] core_tap_A;
   logic [31:0] core_tap_Do;
   logic        ap_start_o;
   logic [31:0] data_length;
   logic        core_done;

   fir_cfg_ctrl_if #(.ADDR_W(12), .DATA_W(32)) bus ();

   fir_cfg_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(TAPS)) dut (
      .axis_clk    (axis_clk),
      .axis_rst_n  (axis_rst_n),
      .axil        (bus.slave),
      .tap_WE      (tap_WE),
      .tap_EN      (tap_EN),
      .tap_Di      (tap_Di),
      .tap_A       (tap_A),
      .tap_Do      (tap_Do),
      .core_tap_en (core_tap_en),
      .core_tap_A  (core_tap_A),
      .core_tap_Do (core_tap_Do),
      .ap_start_o  (ap_start_o),
      .data_length (data_length),
      .core_done   (core_done)
   );

   always #5 axis_clk = ~axis_clk;

   // bram11 model: synchronous read-first single port
   logic [31:0] ram [TAPS] = '{default: 32'h0};
   always @(posedge axis_clk) begin
      if (tap_EN && int'(tap_A[11:2]) < TAPS) begin
         if (tap_WE == 4'hF) ram[int'(tap_A[11:2])] <= tap_Di;
         tap_Do <= ram[int'(tap_A[11:2])];
      end
   end

   int n_cmp = 0;
   int n_fail = 0;
   int start_pulses = 0;
   int we_cycles = 0;

   always @(negedge axis_clk) begin
      if (ap_start_o === 1'b1) start_pulses++;
      if (tap_WE !== 4'h0) we_cycles++;
   end

   // host-visible reference state
   logic [31:0] ref_taps [TAPS] = '{default: 32'h0};
   logic [31:0] ref_len = 32'h0;
   logic        ref_idle = 1'b1;
   logic        ref_done = 1'b0;
   int          ref_starts = 0;
   int          exp_we = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int tap_idx(input logic [11:0] a);
      int ia;
      ia = int'(a);
      if (ia >= 32 && ia < 32 + 4 * TAPS && ia % 4 == 0) return (ia - 32) / 4;
      return -1;
   endfunction

   function automatic logic [31:0] exp_read(input logic [11:0] a);
      int k;
      k = tap_idx(a);
      if (a == 12'h000) return {29'd0, ref_idle, ref_done, 1'b0};
      if (a == 12'h010) return ref_len;
      if (k >= 0) return ref_idle ? ref_taps[k] : 32'hFFFF_FFFF;
      return 32'h0;
   endfunction

   task automatic host_write(input logic [11:0] a, input logic [31:0] d, input bit with_done);
      int  n;
      int  k;
      bit  start_exp;
      n = 0;
      k = tap_idx(a);
      start_exp = (a == 12'h000) && d[0] && ref_idle;
      bus.awaddr  = a;
      bus.wdata   = d;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      do begin
         @(negedge axis_clk);
         n++;
      end while (!bus.awready && n < 20);
      check("aw_handshake", 32'(bus.awready & bus.wready), 32'h1);
      if (k >= 0 && ref_idle) begin
         check("wr_tap_we", 32'(tap_WE), 32'hF);
         check("wr_tap_a", 32'(tap_A), 32'(a) - 32'h20);
         check("wr_tap_di", tap_Di, d);
      end else begin
         check("wr_no_we", 32'(tap_WE), 32'h0);
      end
      if (with_done) core_done = 1'b1;
      @(negedge axis_clk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      core_done   = 1'b0;
      if (start_exp) begin
         check("start_pulse_hi", 32'(ap_start_o), 32'h1);
         @(negedge axis_clk);
         check("start_pulse_lo", 32'(ap_start_o), 32'h0);
         ref_idle = 1'b0;
         ref_done = 1'b0;
         ref_starts++;
      end else begin
         check("no_start", 32'(ap_start_o), 32'h0);
         if (a == 12'h010 && ref_idle) ref_len = d;
         if (k >= 0 && ref_idle) begin
            ref_taps[k] = d;
            exp_we++;
         end
      end
      if (with_done && !ref_idle) begin
         ref_idle = 1'b1;
         ref_done = 1'b1;
      end
   endtask

   task automatic axi_read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp,
                               input int exp_lat);
      int n;
      bit seen_ar;
      n = 0;
      seen_ar = 1'b0;
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      bus.rready  = 1'b0;
      while (!bus.rvalid && n < 20) begin
         @(negedge axis_clk);
         n++;
         if (seen_ar) bus.arvalid = 1'b0;
         if (bus.arready) seen_ar = 1'b1;
      end
      bus.arvalid = 1'b0;
      check({tag, "_rvalid"}, 32'(bus.rvalid), 32'h1);
      check({tag, "_lat"}, 32'(n - 1), 32'(exp_lat));
      check({tag, "_data"}, bus.rdata, exp);
      repeat ($urandom_range(0, 2)) @(negedge axis_clk);
      check({tag, "_hold"}, 32'(bus.rvalid), 32'h1);
      bus.rready = 1'b1;
      @(negedge axis_clk);
      bus.rready = 1'b0;
      check({tag, "_rdone"}, 32'(bus.rvalid), 32'h0);
   endtask

   task automatic pulse_done();
      core_done = 1'b1;
      @(negedge axis_clk);
      core_done = 1'b0;
      if (!ref_idle) begin
         ref_idle = 1'b1;
         ref_done = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [11:0] a;
      logic [31:0] d;
      int          sel;
      int          coef [TAPS];
      coef = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

      axis_rst_n  = 1'b0;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      bus.awaddr  = '0;
      bus.wdata   = '0;
      bus.araddr  = '0;
      core_done   = 1'b0;
      core_tap_en = 1'b0;
      core_tap_A  = '0;
      repeat (3) @(negedge axis_clk);
      check("rst_awready", 32'(bus.awready), 32'h0);
      check("rst_wready", 32'(bus.wready), 32'h0);
      check("rst_arready", 32'(bus.arready), 32'h0);
      check("rst_rvalid", 32'(bus.rvalid), 32'h0);
      check("rst_rdata", bus.rdata, 32'h0);
      check("rst_tap_en", 32'(tap_EN), 32'h0);
      check("rst_tap_we", 32'(tap_WE), 32'h0);
      check("rst_start", 32'(ap_start_o), 32'h0);
      check("rst_len", data_length, 32'h0);
      axis_rst_n = 1'b1;
      @(negedge axis_clk);
      axi_read_chk("ctrl_after_rst", 12'h000, 32'h4, 2);

      // randomized idle-time traffic over mapped, unmapped and unaligned addresses
      for (int i = 0; i < 24; i++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0: a = 12'h010;
            1: a = 12'h004;
            2: a = 12'h014;
            3: a = 12'h04C;
            4: a = 12'h100;
            5: a = 12'h022;
            default: a = 12'(32'h20 + 4 * $urandom_range(0, TAPS - 1));
         endcase
         d = $urandom;
         if ($urandom_range(0, 1) == 1) host_write(a, d, 1'b0);
         else axi_read_chk("rand_rd", a, exp_read(a), 2);
         repeat ($urandom_range(0, 2)) @(negedge axis_clk);
      end

      host_write(12'h010, 32'd600, 1'b0);
      for (int k = 0; k < TAPS; k++) host_write(12'(32'h20 + 4 * k), 32'(coef[k]), 1'b0);
      axi_read_chk("len_rd", 12'h010, 32'd600, 2);
      for (int k = 0; k < TAPS; k++)
         axi_read_chk($sformatf("tap_rd_%0d", k), 12'(32'h20 + 4 * k), 32'(coef[k]), 2);
      check("len_port", data_length, 32'd600);

      // start a run; datapath owns the RAM port
      host_write(12'h000, 32'h1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         core_tap_en = 1'($urandom_range(0, 1));
         core_tap_A  = 12'(4 * $urandom_range(0, TAPS - 1));
         #1;
         check("run_tap_en", 32'(tap_EN), 32'(core_tap_en));
         check("run_tap_a", 32'(tap_A), 32'(core_tap_A));
         check("run_tap_we", 32'(tap_WE), 32'h0);
         @(negedge axis_clk);
      end
      core_tap_en = 1'b0;
      axi_read_chk("ctrl_busy", 12'h000, exp_read(12'h000), 2);
      host_write(12'h024, 32'd99, 1'b0);
      axi_read_chk("tap_busy_rd", 12'h024, 32'hFFFF_FFFF, 2);
      check("ram_unchanged", ram[1], ref_taps[1]);
      host_write(12'h010, 32'd5, 1'b0);
      axi_read_chk("len_busy", 12'h010, 32'd600, 2);
      host_write(12'h000, 32'h1, 1'b0);

      pulse_done();
      axi_read_chk("ctrl_done", 12'h000, 32'h6, 2);
      axi_read_chk("tap_after_done", 12'h024, 32'hFFFF_FFF6, 2);

      host_write(12'h000, 32'h1, 1'b0);
      axi_read_chk("ctrl_restart", 12'h000, 32'h0, 2);
      host_write(12'h000, 32'h1, 1'b1);
      axi_read_chk("ctrl_start_vs_done", 12'h000, 32'h6, 2);
      pulse_done();
      axi_read_chk("ctrl_idle_done_ign", 12'h000, 32'h6, 2);

      // same-cycle host write and read of one tap: write first, read delayed
      d = $urandom;
      fork
         host_write(12'h028, d, 1'b0);
         axi_read_chk("collide_rd", 12'h028, d, 3);
      join
      check("ram_collide", ram[2], d);

      // reset in the middle of a run
      host_write(12'h000, 32'h1, 1'b0);
      repeat (3) @(negedge axis_clk);
      axis_rst_n = 1'b0;
      repeat (2) @(negedge axis_clk);
      check("midrst_start", 32'(ap_start_o), 32'h0);
      check("midrst_tap_en", 32'(tap_EN), 32'h0);
      axis_rst_n = 1'b1;
      ref_idle = 1'b1;
      ref_done = 1'b0;
      ref_len  = 32'h0;
      @(negedge axis_clk);
      check("midrst_no_pulse", 32'(ap_start_o), 32'h0);
      axi_read_chk("ctrl_midrst", 12'h000, 32'h4, 2);
      axi_read_chk("len_midrst", 12'h010, 32'h0, 2);
      check("len_port_midrst", data_length, 32'h0);

      check("start_pulses", 32'(start_pulses), 32'(ref_starts));
      check("we_cycles", 32'(we_cycles), 32'(exp_we));
      for (int k = 0; k < TAPS; k++) check($sformatf("ram_%0d", k), ram[k], ref_taps[k]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/fir_cfg_ctrl.md
Name: fir_cfg_ctrl

Overview:
- AXI4-Lite configuration and control front-end for the FIR engine.
- Holds the ap_ctrl register (ap_start, ap_done, ap_idle) and the data_length register.
- Owns the single port of the tap-coefficient BRAM (bram11) and arbitrates it between AXI-Lite host accesses and the FIR datapath's coefficient fetches.
- Sits between the AXI-Lite bus and the FIR core and tap RAM. It sequences start/done of the core.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite and tap RAM address width
- pDATA_WIDTH, 32, data width
- Tape_Num, 11, number of coefficients

Ports:
- axis_clk  in  1  clock
- axis_rst_n  in  1  reset, synchronous, active-low
- awvalid/awready  in/out  1  AXI-Lite write address handshake
- awaddr  in  12  write address
- wvalid/wready  in/out  1  AXI-Lite write data handshake
- wdata  in  32  write data
- arvalid/arready  in/out  1  read address handshake
- araddr  in  12  read address
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  32  read data
- tap_WE  out  4  tap RAM byte write enables
- tap_EN  out  1  tap RAM enable
- tap_Di  out  32  tap RAM write data
- tap_A  out  12  tap RAM byte address
- tap_Do  in  32  tap RAM read data
- core_tap_en  in  1  datapath coefficient read request
- core_tap_A  in  12  datapath coefficient byte address
- core_tap_Do  out  32  coefficient data to datapath (tap_Do forwarded)
- ap_start_o  out  1  one-cycle start pulse to core
- data_length  out  32  sample count register
- core_done  in  1  one-cycle pulse when the last output is accepted

Behaviour:
- Reset (axis_rst_n=0 at posedge):
  - awready, wready, arready, rvalid = 0; rdata = 0.
  - ap_start = 0, ap_done = 0, ap_idle = 1, data_length = 0.
  - tap_EN = 0, tap_WE = 0.
  - Any in-flight transaction is abandoned. Reset mid-run returns to idle with no start pulse.
- Address map:
  - 0x00 ap_ctrl: bit0 ap_start (W1 to start), bit1 ap_done (RO), bit2 ap_idle (RO); other bits read 0.
  - 0x10 data_length (RW).
  - 0x20 + 4k, k = 0..Tape_Num-1: tap k. tap_A = addr - 0x20.
  - Other addresses: writes ignored, reads return 0.
- Write channel:
  - Accepted in the first cycle where awvalid & wvalid are both high and no write response is pending.
  - awready and wready pulse high together for exactly that one cycle.
  - The register or tap write takes effect in the same cycle: tap_EN = 1, tap_WE = 4'hF.
- Read channel FSM: R_IDLE -> R_ADDR -> R_DATA.
  - R_IDLE: arvalid=1 -> R_ADDR.
  - R_ADDR: arready=1 for one cycle; araddr latched; for a tap address, tap_EN = 1 and tap_WE = 0 are driven.
  - R_DATA: rdata is captured (tap_Do, or the register value) and rvalid = 1 is held until rready. Then -> R_IDLE.
  - Latency: rvalid rises 2 cycles after arvalid is first sampled high.
- Tap port arbitration:
  - While ap_idle = 0, the datapath owns the port: tap_EN = core_tap_en, tap_A = core_tap_A, tap_WE = 0.
  - While busy, host tap writes are dropped (the handshake still completes) and host tap reads return 0xFFFFFFFF.
  - ap_ctrl and data_length remain accessible while busy. data_length writes while busy are ignored.
  - While idle, if a host write and a host read both target the tap port in the same cycle, the write wins and the read's R_ADDR phase is extended by one cycle.
- ap_start:
  - A write to 0x00 with wdata[0]=1 while ap_idle=1 sets ap_start for exactly one cycle and pulses ap_start_o.
  - The next cycle: ap_idle = 0, ap_done = 0.
  - A start write while busy is ignored.
- core_done:
  - On the pulse, the next cycle: ap_done = 1, ap_idle = 1.
  - ap_done stays set until the next accepted ap_start.
  - core_done while idle is ignored.
- Simultaneous events:
  - A start write in the same cycle as core_done is ignored (the core is still busy in that cycle). The host must re-issue it.
  - A read of 0x00 in the same cycle as a status update returns the pre-update value.

Test Plan:
- Reset, then read 0x00 -> rdata = 0x4 (idle=1, done=0). rvalid rises 2 cycles after arvalid.
- Write data_length = 600, taps {0,-10,-9,23,56,63,56,23,-9,-10,0} at 0x20..0x48, then read all back -> exact values; tap_WE = F only on the write cycles.
- Write 0x00 = 1 -> ap_start_o high for 1 cycle; next read of 0x00 has bit2 = 0; during the run, tap_A follows core_tap_A.
- Busy: write tap 0x24 = 99 and read 0x24 -> RAM unchanged, rdata = 0xFFFFFFFF. After done, read 0x24 -> -10.
- Pulse core_done -> read 0x00 returns 0x6. A second start write produces a new pulse and clears done.
- Start write coinciding with core_done -> no ap_start_o. Assert reset mid-run -> 0x00 reads 0x4 and data_length = 0.
